// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven hours/minutes editor with auto-repeat, timeout abort and one-cycle commit pulse
module time_set_ctrl #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_RATE    = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [4:0] cur_hours,
   input  logic [5:0] cur_minutes,
   output logic [4:0] set_hours,
   output logic [5:0] set_minutes,
   output logic       propagate,
   output logic       editing,
   output logic       field_sel
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EDIT_H = 2'd1;
   localparam logic [1:0] S_EDIT_M = 2'd2;
   localparam logic [1:0] S_COMMIT = 2'd3;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW = $clog2(RMAX + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    state_q, state_d;
   logic [4:0]    set_hours_q, set_hours_d;
   logic [5:0]    set_minutes_q, set_minutes_d;
   logic          propagate_q, propagate_d;
   logic          editing_q, editing_d;
   logic          field_sel_q, field_sel_d;
   logic          mode_prev_q, up_prev_q, dn_prev_q;
   logic [RW-1:0] rep_q, rep_d;
   logic          rpt_q, rpt_d;
   logic [TW-1:0] to_q, to_d;
   logic          mode_ev, up_ev, dn_ev, in_edit, alone, rep_hit, step;
   logic [4:0]    hr_up, hr_dn;
   logic [5:0]    mn_up, mn_dn;

   // edge detect and auto-repeat: rep_q counts cycles since the last step (0 = not armed)
   always_comb begin
      mode_ev = btn_mode & ~mode_prev_q;
      up_ev   = btn_up & ~up_prev_q;
      dn_ev   = btn_down & ~dn_prev_q;
      in_edit = (state_q == S_EDIT_H) || (state_q == S_EDIT_M);
      alone   = btn_up ^ btn_down;
      rep_hit = rep_q == (rpt_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY));
      step    = 1'b0;
      rep_d   = '0;
      rpt_d   = 1'b0;
      if (in_edit && alone) begin
         if (up_ev || dn_ev) begin
            step  = 1'b1;
            rep_d = RW'(1);
         end else if (rep_q != '0) begin
            step  = rep_hit;
            rep_d = rep_hit ? RW'(1) : rep_q + RW'(1);
            rpt_d = rep_hit | rpt_q;
         end
      end
   end

   // session FSM, field wrap arithmetic and idle timeout
   always_comb begin
      hr_up         = (set_hours_q == 5'd23) ? 5'd0 : set_hours_q + 5'd1;
      hr_dn         = (set_hours_q == 5'd0) ? 5'd23 : set_hours_q - 5'd1;
      mn_up         = (set_minutes_q == 6'd59) ? 6'd0 : set_minutes_q + 6'd1;
      mn_dn         = (set_minutes_q == 6'd0) ? 6'd59 : set_minutes_q - 6'd1;
      state_d       = state_q;
      set_hours_d   = set_hours_q;
      set_minutes_d = set_minutes_q;
      to_d          = '0;
      case (state_q)
         S_IDLE: begin
            if (mode_ev) begin
               state_d       = S_EDIT_H;
               set_hours_d   = cur_hours;
               set_minutes_d = cur_minutes;
            end
         end
         S_EDIT_H, S_EDIT_M: begin
            if (mode_ev)
               state_d = (state_q == S_EDIT_H) ? S_EDIT_M : S_COMMIT;
            else if (step) begin
               set_hours_d   = (state_q == S_EDIT_H) ? (btn_up ? hr_up : hr_dn) : set_hours_q;
               set_minutes_d = (state_q == S_EDIT_M) ? (btn_up ? mn_up : mn_dn) : set_minutes_q;
            end else if (to_q == TW'(TIMEOUT_CYCLES - 1))
               state_d = S_IDLE;
            else
               to_d = to_q + TW'(1);
         end
         default: state_d = S_IDLE;
      endcase
      propagate_d = state_d == S_COMMIT;
      editing_d   = (state_d == S_EDIT_H) || (state_d == S_EDIT_M);
      field_sel_d = state_d == S_EDIT_M;
   end

   // state registers; button history resets high so a button held through reset needs a fresh press
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         set_hours_q   <= '0;
         set_minutes_q <= '0;
         propagate_q   <= 1'b0;
         editing_q     <= 1'b0;
         field_sel_q   <= 1'b0;
         mode_prev_q   <= 1'b1;
         up_prev_q     <= 1'b1;
         dn_prev_q     <= 1'b1;
         rep_q         <= '0;
         rpt_q         <= 1'b0;
         to_q          <= '0;
      end else begin
         state_q       <= state_d;
         set_hours_q   <= set_hours_d;
         set_minutes_q <= set_minutes_d;
         propagate_q   <= propagate_d;
         editing_q     <= editing_d;
         field_sel_q   <= field_sel_d;
         mode_prev_q   <= btn_mode;
         up_prev_q     <= btn_up;
         dn_prev_q     <= btn_down;
         rep_q         <= rep_d;
         rpt_q         <= rpt_d;
         to_q          <= to_d;
      end
   end

   assign set_hours   = set_hours_q;
   assign set_minutes = set_minutes_q;
   assign propagate   = propagate_q;
   assign editing     = editing_q;
   assign field_sel   = field_sel_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;
   logic       clk = 1'b0;
   logic       reset, btn_mode, btn_up, btn_down;
   logic [4:0] cur_hours, set_hours;
   logic [5:0] cur_minutes, set_minutes;
   logic       propagate, editing, field_sel;
   int         total = 0;
   int         bad = 0;

   time_set_ctrl #(.TIMEOUT_CYCLES(20), .REPEAT_DELAY(5), .REPEAT_RATE(2)) dut (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
      .cur_hours(cur_hours), .cur_minutes(cur_minutes), .set_hours(set_hours),
      .set_minutes(set_minutes), .propagate(propagate), .editing(editing), .field_sel(field_sel)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic [31:0] h, input logic [31:0] m,
                       input logic [31:0] p, input logic [31:0] e, input logic [31:0] f);
      chk({tag, "_hours"}, set_hours, h);
      chk({tag, "_minutes"}, set_minutes, m);
      chk({tag, "_propagate"}, propagate, p);
      chk({tag, "_editing"}, editing, e);
      chk({tag, "_field_sel"}, field_sel, f);
   endtask

   task automatic mode_press();
      btn_mode = 1'b1;
      cyc(1);
   endtask

   task automatic mode_release();
      btn_mode = 1'b0;
      cyc(1);
   endtask

   initial begin
      reset = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      cur_hours = 5'd10; cur_minutes = 6'd20;
      cyc(3);
      outs("reset", 0, 0, 0, 0, 0);
      reset = 1'b1;
      cyc(1);
      // plain session: mode x3, no steps
      mode_press();
      outs("t1_edit_h", 10, 20, 0, 1, 0);
      mode_release();
      mode_press();
      outs("t1_edit_m", 10, 20, 0, 1, 1);
      mode_release();
      mode_press();
      outs("t1_commit", 10, 20, 1, 0, 0);
      mode_release();
      outs("t1_idle", 10, 20, 0, 0, 0);
      // wrap-around both fields
      cur_hours = 5'd23; cur_minutes = 6'd0;
      mode_press();
      outs("t2_load", 23, 0, 0, 1, 0);
      mode_release();
      btn_up = 1'b1;
      cyc(1);
      chk("t2_hour_wrap", set_hours, 0);
      btn_up = 1'b0;
      cyc(1);
      mode_press();
      mode_release();
      btn_down = 1'b1;
      cyc(1);
      chk("t2_min_wrap", set_minutes, 59);
      btn_down = 1'b0;
      cyc(1);
      mode_press();
      outs("t2_commit", 0, 59, 1, 0, 0);
      mode_release();
      chk("t2_prop_single", propagate, 0);
      cyc(1);
      chk("t2_prop_low", propagate, 0);
      // auto-repeat in EDIT_M, steps at held cycles 0,5,7,9,11
      cur_hours = 5'd7; cur_minutes = 6'd30;
      mode_press();
      mode_release();
      mode_press();
      mode_release();
      chk("t3_start", set_minutes, 30);
      btn_up = 1'b1;
      cyc(1);
      chk("t3_first_step", set_minutes, 31);
      cyc(4);
      chk("t3_before_delay", set_minutes, 31);
      cyc(1);
      chk("t3_after_delay", set_minutes, 32);
      cyc(6);
      chk("t3_after_12", set_minutes, 35);
      btn_up = 1'b0;
      cyc(1);
      chk("t3_released", set_minutes, 35);
      btn_up = 1'b1; btn_down = 1'b1;
      cyc(8);
      chk("t3_both_held", set_minutes, 35);
      btn_up = 1'b0; btn_down = 1'b0;
      cyc(1);
      mode_press();
      outs("t3_commit", 7, 35, 1, 0, 0);
      mode_release();
      // timeout abort after 20 idle cycles
      cur_hours = 5'd4; cur_minutes = 6'd10;
      mode_press();
      mode_release();
      btn_up = 1'b1;
      cyc(1);
      chk("t4_step", set_hours, 5);
      btn_up = 1'b0;
      for (int i = 0; i < 19; i++) begin
         cyc(1);
         chk("t4_no_prop", propagate, 0);
      end
      chk("t4_still_edit", editing, 1);
      cyc(1);
      outs("t4_timeout", 5, 10, 0, 0, 0);
      cyc(2);
      chk("t4_no_prop_after", propagate, 0);
      // reset in the commit cycle, up held through reset
      cur_hours = 5'd12; cur_minutes = 6'd34;
      mode_press();
      mode_release();
      mode_press();
      mode_release();
      btn_mode = 1'b1; btn_up = 1'b1; reset = 1'b0;
      cyc(1);
      outs("t5_reset", 0, 0, 0, 0, 0);
      btn_mode = 1'b0; reset = 1'b1;
      cyc(1);
      chk("t5_post_prop", propagate, 0);
      mode_press();
      mode_release();
      cyc(2);
      outs("t5_held_up", 12, 34, 0, 1, 0);
      btn_up = 1'b0;
      cyc(1);
      btn_up = 1'b1;
      cyc(1);
      chk("t5_repress", set_hours, 13);
      btn_up = 1'b0;
      cyc(1);
      // mode and up edges together: mode wins
      btn_mode = 1'b1; btn_up = 1'b1;
      cyc(1);
      outs("t6_mode_wins", 13, 34, 0, 1, 1);
      btn_mode = 1'b0; btn_up = 1'b0;
      cyc(1);
      mode_press();
      outs("t6_commit", 13, 34, 1, 0, 0);
      mode_release();
      chk("t6_prop_low", propagate, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
